rv32i_multicycle_control: RTL and testbench
===========================================

RV32I_MULTICYCLE_CONTROL -- requirements
Module: rv32i_multicycle_control

Interface
REQ-001 SHALL have parameter MEM_WAIT_CYCLES, default 0, range 0..15: extra wait cycles per memory access (fetch, load, store).
REQ-002 SHALL have parameter ENABLE_JAL, default 1: 1 = JAL decoded; 0 = JAL treated as illegal.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 ena  input  1  global enable; low freezes state and counter, forces all write strobes to 0.
REQ-006 instr  input  32  instruction register contents.
REQ-007 zero  input  1  ALU zero flag.
REQ-008 pc_write  output  1  PC register enable.
REQ-009 ir_write  output  1  instruction/PC_old register enable.
REQ-010 addr_src  output  1  memory address select: 0 = PC, 1 = result.
REQ-011 mem_wr_ena  output  1  memory write strobe.
REQ-012 reg_write  output  1  register file write enable.
REQ-013 alu_src_a  output  2  00 PC, 01 PC_old, 10 rs1 register.
REQ-014 alu_src_b  output  2  00 rs2 register, 01 imm_ext, 10 constant 4.
REQ-015 result_src  output  2  00 alu_out, 01 data, 10 alu_result.
REQ-016 imm_src  output  2  00 I, 01 S, 10 B, 11 J.
REQ-017 alu_control  output  alu_control_t  ALU operation.
REQ-018 illegal  output  1  sticky illegal-instruction flag.

Function
REQ-019 SHALL be a Moore FSM; outputs SHALL depend on state, wait counter and instr only. States: FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, ALU_WB, BRANCH, JAL, TRAP.
REQ-020 FETCH, MEM_READ and MEM_WRITE SHALL last 1+MEM_WAIT_CYCLES enabled cycles, using a 4-bit wait counter cleared on each state entry.
REQ-021 In FETCH: addr_src=0, alu_src_a=00, alu_src_b=10, alu_control=ADD, result_src=10. ir_write and pc_write SHALL be 1 on the final fetch cycle only. Next state: DECODE.
REQ-022 In DECODE: alu_src_a=01, alu_src_b=01, imm_src=10, alu_control=ADD. Opcode dispatch: 0000011/0100011 -> MEM_ADR; 0110011 -> EXEC_R; 0010011 -> EXEC_I; 1100011 -> BRANCH; 1101111 -> JAL (if ENABLE_JAL); any other opcode -> TRAP.
REQ-023 In MEM_ADR: alu_src_a=10, alu_src_b=01, alu_control=ADD, imm_src=00 for load, 01 for store. Next state: MEM_READ for load, MEM_WRITE for store.
REQ-024 In MEM_READ: addr_src=1, result_src=00. Next state: MEM_WB after the final cycle.
REQ-025 In MEM_WRITE: addr_src=1, result_src=00. mem_wr_ena=1 on the final cycle only. Next state: FETCH.
REQ-026 In MEM_WB: result_src=01, reg_write=1. Next state: FETCH.
REQ-027 In EXEC_R/EXEC_I: alu_src_a=10; alu_src_b=00 (R) or 01 (I, imm_src=00). alu_control from funct3: ADD/SUB (SUB only if R and instr[30]), SLL, SLT, SLTU, XOR, SRL/SRA (by instr[30]), OR, AND. Next state: ALU_WB.
REQ-028 In ALU_WB: result_src=00, reg_write=1. Next state: FETCH.
REQ-029 In BRANCH: alu_src_a=10, alu_src_b=00, alu_control=SUB, result_src=00. pc_write = zero for funct3 000, ~zero for funct3 001. Other funct3 -> TRAP with pc_write=0. Otherwise next state: FETCH.
REQ-030 In JAL: alu_src_a=01, alu_src_b=10, alu_control=ADD, result_src=00, pc_write=1. Next state: ALU_WB.
REQ-031 TRAP SHALL assert illegal=1 and hold all strobes at 0 until reset.
REQ-032 With ena=0, state and counter SHALL hold, and pc_write, ir_write, mem_wr_ena and reg_write SHALL be 0. When ena returns high, operation SHALL resume in the same state with the same counter value.
REQ-033 Unlisted outputs in any state SHALL be 0, or ADD for alu_control.

Reset
REQ-034 While rst=0: state=FETCH, counter=0, illegal=0, all strobes 0. This SHALL take effect immediately, including mid-instruction or mid-wait.
REQ-035 After rst deasserts, the first enabled cycle SHALL be the first FETCH cycle.

Verification
REQ-036 MEM_WAIT_CYCLES=0, instr=0x002081B3 (add x3,x1,x2) -> FETCH, DECODE, EXEC_R (alu_control=ADD), ALU_WB (reg_write=1): 4 cycles.
REQ-037 MEM_WAIT_CYCLES=2, instr=0x0080A283 (lw x5,8(x1)) -> 9 cycles. ir_write is 1 only in cycle 3. MEM_WB reg_write=1 with result_src=01.
REQ-038 instr=0x00208463 (beq) -> 3 cycles, with zero=1 giving pc_write=1 in BRANCH. Repeat with zero=0 -> pc_write=0.
REQ-039 instr=0x010000EF (jal x1,16) with ENABLE_JAL=1 -> JAL pc_write=1, then ALU_WB. With ENABLE_JAL=0 -> TRAP, illegal=1 held for 20 cycles.
REQ-040 ena dropped for 3 cycles during MEM_WRITE with MEM_WAIT_CYCLES=1 -> no mem_wr_ena while ena=0. Exactly one mem_wr_ena pulse after resume.
REQ-041 rst asserted mid-MEM_READ -> outputs revert to reset values immediately. After release, the next cycle is FETCH.

Source files
------------

// File: rtl/rv32i_multicycle_control_if.sv
// Control-to-datapath bundle for the RV32I multicycle controller, plus its shared types.
package rv32i_multicycle_control_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_control_t;

endpackage

interface rv32i_multicycle_control_if;
    import rv32i_multicycle_control_pkg::*;

    logic         ena;
    logic [31:0]  instr;
    logic         zero;
    logic         pc_write;
    logic         ir_write;
    logic         addr_src;
    logic         mem_wr_ena;
    logic         reg_write;
    logic [1:0]   alu_src_a;
    logic [1:0]   alu_src_b;
    logic [1:0]   result_src;
    logic [1:0]   imm_src;
    alu_control_t alu_control;
    logic         illegal;

    // Controller side: consumes status, drives the datapath controls.
    modport master (
        input  ena, instr, zero,
        output pc_write, ir_write, addr_src, mem_wr_ena, reg_write,
               alu_src_a, alu_src_b, result_src, imm_src, alu_control, illegal
    );

    // Datapath side.
    modport slave (
        output ena, instr, zero,
        input  pc_write, ir_write, addr_src, mem_wr_ena, reg_write,
               alu_src_a, alu_src_b, result_src, imm_src, alu_control, illegal
    );

endinterface

// File: rtl/rv32i_multicycle_control.sv
// Moore control FSM for a multicycle RV32I subset datapath with configurable memory wait states.
module rv32i_multicycle_control
    import rv32i_multicycle_control_pkg::*;
#(
    parameter int unsigned MEM_WAIT_CYCLES = 0,
    parameter bit          ENABLE_JAL      = 1'b1
) (
    input  logic clk,
    input  logic rst,
    rv32i_multicycle_control_if.master bus
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_WAIT_CYCLES);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
        S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JAL, S_TRAP
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       bit30;
    logic       wait_last;
    logic       strobe_ok;
    logic       pc_write_raw, ir_write_raw, mem_wr_raw, reg_write_raw;

    assign opcode    = bus.instr[6:0];
    assign funct3    = bus.instr[14:12];
    assign bit30     = bus.instr[30];
    assign wait_last = (cnt == WAIT_LAST);
    // Strobes are suppressed while frozen or held in reset, independent of state.
    assign strobe_ok = bus.ena & rst;

    // ALU operation for register and immediate arithmetic; SUB only exists in R form.
    function automatic alu_control_t alu_op(input logic [2:0] f3, input logic b30, input logic is_r);
        alu_control_t op;
        case (f3)
            3'b000:  op = (is_r && b30) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = b30 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // State and wait counter; both freeze while ena is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_FETCH;
            cnt   <= '0;
        end else if (bus.ena) begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state and wait-counter logic; counter clears on every state change.
    always_comb begin
        state_nx = state;
        cnt_nx   = '0;
        case (state)
            S_FETCH: begin
                if (wait_last) state_nx = S_DECODE;
                else           cnt_nx   = cnt + CNT_W'(1);
            end
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_nx = S_MEM_ADR;
                    OP_R:              state_nx = S_EXEC_R;
                    OP_I:              state_nx = S_EXEC_I;
                    OP_BRANCH:         state_nx = S_BRANCH;
                    OP_JAL:            state_nx = ENABLE_JAL ? S_JAL : S_TRAP;
                    default:           state_nx = S_TRAP;
                endcase
            end
            S_MEM_ADR:   state_nx = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ: begin
                if (wait_last) state_nx = S_MEM_WB;
                else           cnt_nx   = cnt + CNT_W'(1);
            end
            S_MEM_WRITE: begin
                if (wait_last) state_nx = S_FETCH;
                else           cnt_nx   = cnt + CNT_W'(1);
            end
            S_MEM_WB:    state_nx = S_FETCH;
            S_EXEC_R:    state_nx = S_ALU_WB;
            S_EXEC_I:    state_nx = S_ALU_WB;
            S_ALU_WB:    state_nx = S_FETCH;
            S_BRANCH:    state_nx = (funct3 == 3'b000 || funct3 == 3'b001) ? S_FETCH : S_TRAP;
            S_JAL:       state_nx = S_ALU_WB;
            S_TRAP:      state_nx = S_TRAP;
            default:     state_nx = S_FETCH;
        endcase
    end

    // Moore output decode from state, counter and instruction fields.
    always_comb begin
        pc_write_raw    = 1'b0;
        ir_write_raw    = 1'b0;
        mem_wr_raw      = 1'b0;
        reg_write_raw   = 1'b0;
        bus.addr_src    = 1'b0;
        bus.alu_src_a   = 2'b00;
        bus.alu_src_b   = 2'b00;
        bus.result_src  = 2'b00;
        bus.imm_src     = 2'b00;
        bus.alu_control = ALU_ADD;
        bus.illegal     = 1'b0;
        case (state)
            S_FETCH: begin
                bus.alu_src_b  = 2'b10;
                bus.result_src = 2'b10;
                ir_write_raw   = wait_last;
                pc_write_raw   = wait_last;
            end
            S_DECODE: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b01;
                bus.imm_src   = 2'b10;
            end
            S_MEM_ADR: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
                bus.imm_src   = (opcode == OP_LOAD) ? 2'b00 : 2'b01;
            end
            S_MEM_READ: begin
                bus.addr_src = 1'b1;
            end
            S_MEM_WRITE: begin
                bus.addr_src = 1'b1;
                mem_wr_raw   = wait_last;
            end
            S_MEM_WB: begin
                bus.result_src = 2'b01;
                reg_write_raw  = 1'b1;
            end
            S_EXEC_R: begin
                bus.alu_src_a   = 2'b10;
                bus.alu_control = alu_op(funct3, bit30, 1'b1);
            end
            S_EXEC_I: begin
                bus.alu_src_a   = 2'b10;
                bus.alu_src_b   = 2'b01;
                bus.alu_control = alu_op(funct3, bit30, 1'b0);
            end
            S_ALU_WB: begin
                reg_write_raw = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a   = 2'b10;
                bus.alu_control = ALU_SUB;
                if (funct3 == 3'b000)      pc_write_raw = bus.zero;
                else if (funct3 == 3'b001) pc_write_raw = ~bus.zero;
            end
            S_JAL: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b10;
                pc_write_raw  = 1'b1;
            end
            S_TRAP: begin
                bus.illegal = 1'b1;
            end
            default: ;
        endcase
    end

    // Gated write strobes.
    assign bus.pc_write   = pc_write_raw  & strobe_ok;
    assign bus.ir_write   = ir_write_raw  & strobe_ok;
    assign bus.mem_wr_ena = mem_wr_raw    & strobe_ok;
    assign bus.reg_write  = reg_write_raw & strobe_ok;

endmodule

// File: tb/tb_rv32i_multicycle_control.sv
// Bench for rv32i_multicycle_control: three parameterisations checked against a per-instruction cycle model.
module tb_rv32i_multicycle_control;
    import rv32i_multicycle_control_pkg::*;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       addr_src;
        logic       mem_wr_ena;
        logic       reg_write;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] res;
        logic [1:0] imm;
        logic [3:0] alu;
        logic       illegal;
    } out_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ena_v   [3];
    logic [31:0] instr_v [3];
    logic        zero_v  [3];
    out_t        obs     [3];
    out_t        exp_q   [$];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rv32i_multicycle_control_if if_a ();
    rv32i_multicycle_control_if if_b ();
    rv32i_multicycle_control_if if_c ();

    rv32i_multicycle_control #(.MEM_WAIT_CYCLES(0), .ENABLE_JAL(1'b1)) u_w0 (.clk(clk), .rst(rst), .bus(if_a));
    rv32i_multicycle_control #(.MEM_WAIT_CYCLES(2), .ENABLE_JAL(1'b1)) u_w2 (.clk(clk), .rst(rst), .bus(if_b));
    rv32i_multicycle_control #(.MEM_WAIT_CYCLES(1), .ENABLE_JAL(1'b0)) u_w1 (.clk(clk), .rst(rst), .bus(if_c));

    assign if_a.ena = ena_v[0];  assign if_a.instr = instr_v[0];  assign if_a.zero = zero_v[0];
    assign if_b.ena = ena_v[1];  assign if_b.instr = instr_v[1];  assign if_b.zero = zero_v[1];
    assign if_c.ena = ena_v[2];  assign if_c.instr = instr_v[2];  assign if_c.zero = zero_v[2];

    assign obs[0] = {if_a.pc_write, if_a.ir_write, if_a.addr_src, if_a.mem_wr_ena, if_a.reg_write,
                     if_a.alu_src_a, if_a.alu_src_b, if_a.result_src, if_a.imm_src, if_a.alu_control, if_a.illegal};
    assign obs[1] = {if_b.pc_write, if_b.ir_write, if_b.addr_src, if_b.mem_wr_ena, if_b.reg_write,
                     if_b.alu_src_a, if_b.alu_src_b, if_b.result_src, if_b.imm_src, if_b.alu_control, if_b.illegal};
    assign obs[2] = {if_c.pc_write, if_c.ir_write, if_c.addr_src, if_c.mem_wr_ena, if_c.reg_write,
                     if_c.alu_src_a, if_c.alu_src_b, if_c.result_src, if_c.imm_src, if_c.alu_control, if_c.illegal};

    function automatic int wait_of(input int d);
        case (d)
            0:       return 0;
            1:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic bit jal_of(input int d);
        return d != 2;
    endfunction

    function automatic out_t blank();
        out_t e;
        e     = '0;
        e.alu = ALU_ADD;
        return e;
    endfunction

    function automatic out_t reset_exp();
        out_t e;
        e       = blank();
        e.src_b = 2'b10;
        e.res   = 2'b10;
        return e;
    endfunction

    // Arithmetic op implied by funct3 and bit 30 for R/I instructions.
    function automatic logic [3:0] exec_alu(input logic [31:0] ins, input bit is_r);
        logic [3:0] tab [8];
        logic [3:0] op;
        tab = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        op  = tab[ins[14:12]];
        if (ins[14:12] == 3'd0 && is_r && ins[30]) op = ALU_SUB;
        if (ins[14:12] == 3'd5 && ins[30])         op = ALU_SRA;
        return op;
    endfunction

    // Expected per-cycle output list for one instruction; traps are followed by 20 held trap cycles.
    task automatic build(input int d, input logic [31:0] ins, input logic z, output bit trapped);
        out_t e;
        int   w;
        bit   is_st;
        w       = wait_of(d);
        trapped = 1'b0;
        exp_q.delete();
        for (int i = 0; i <= w; i++) begin
            e = reset_exp();
            e.ir_write = (i == w);
            e.pc_write = (i == w);
            exp_q.push_back(e);
        end
        e = blank(); e.src_a = 2'b01; e.src_b = 2'b01; e.imm = 2'b10;
        exp_q.push_back(e);
        case (ins[6:0])
            7'b0000011, 7'b0100011: begin
                is_st = (ins[6:0] == 7'b0100011);
                e = blank(); e.src_a = 2'b10; e.src_b = 2'b01; e.imm = is_st ? 2'b01 : 2'b00;
                exp_q.push_back(e);
                for (int i = 0; i <= w; i++) begin
                    e = blank(); e.addr_src = 1'b1; e.mem_wr_ena = is_st && (i == w);
                    exp_q.push_back(e);
                end
                if (!is_st) begin
                    e = blank(); e.res = 2'b01; e.reg_write = 1'b1;
                    exp_q.push_back(e);
                end
            end
            7'b0110011, 7'b0010011: begin
                e = blank(); e.src_a = 2'b10;
                if (ins[6:0] == 7'b0010011) e.src_b = 2'b01;
                e.alu = exec_alu(ins, ins[6:0] == 7'b0110011);
                exp_q.push_back(e);
                e = blank(); e.reg_write = 1'b1;
                exp_q.push_back(e);
            end
            7'b1100011: begin
                e = blank(); e.src_a = 2'b10; e.alu = ALU_SUB;
                if (ins[14:12] == 3'b000)      e.pc_write = z;
                else if (ins[14:12] == 3'b001) e.pc_write = ~z;
                else                           trapped = 1'b1;
                exp_q.push_back(e);
            end
            7'b1101111: begin
                if (jal_of(d)) begin
                    e = blank(); e.src_a = 2'b01; e.src_b = 2'b10; e.pc_write = 1'b1;
                    exp_q.push_back(e);
                    e = blank(); e.reg_write = 1'b1;
                    exp_q.push_back(e);
                end else begin
                    trapped = 1'b1;
                end
            end
            default: trapped = 1'b1;
        endcase
        if (trapped) begin
            for (int i = 0; i < 20; i++) begin
                e = blank(); e.illegal = 1'b1;
                exp_q.push_back(e);
            end
        end
    endtask

    // Runs one instruction on DUT d from its first fetch cycle; optional ena drop and early stop.
    task automatic run_instr(input int d, input logic [31:0] ins, input logic z,
                             input int drop_at, input int drop_len, input int stop_at,
                             input string tag, output bit trapped);
        out_t e;
        int   pulses;
        int   want_pulses;
        pulses      = 0;
        want_pulses = 0;
        build(d, ins, z, trapped);
        instr_v[d] = ins;
        zero_v[d]  = z;
        for (int i = 0; i < exp_q.size() && i < stop_at; i++) begin
            if (i == drop_at) begin
                ena_v[d] = 1'b0;
                for (int k = 0; k < drop_len; k++) begin
                    e = exp_q[i];
                    e.pc_write = 1'b0; e.ir_write = 1'b0; e.mem_wr_ena = 1'b0; e.reg_write = 1'b0;
                    @(negedge clk);
                    total++;
                    if (obs[d] !== e) begin
                        bad++;
                        $display("FAIL %s_frozen dut=%0d cyc=%0d got=%h want=%h", tag, d, i, obs[d], e);
                    end
                    if (obs[d].mem_wr_ena === 1'b1) pulses++;
                    @(posedge clk); #1;
                end
                ena_v[d] = 1'b1;
            end
            @(negedge clk);
            total++;
            if (obs[d] !== exp_q[i]) begin
                bad++;
                $display("FAIL %s dut=%0d cyc=%0d got=%h want=%h", tag, d, i, obs[d], exp_q[i]);
            end
            if (obs[d].mem_wr_ena === 1'b1) pulses++;
            if (exp_q[i].mem_wr_ena) want_pulses++;
            @(posedge clk); #1;
        end
        total++;
        if (pulses != want_pulses) begin
            bad++;
            $display("FAIL %s_wr_pulses dut=%0d got=%0d want=%0d", tag, d, pulses, want_pulses);
        end
    endtask

    // Asserts reset mid-cycle on all DUTs, checks immediate and held reset outputs, releases.
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int d = 0; d < 3; d++) ena_v[d] = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            total++;
            if (obs[d] !== reset_exp()) begin
                bad++;
                $display("FAIL reset_now dut=%0d got=%h want=%h", d, obs[d], reset_exp());
            end
        end
        @(posedge clk); @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            total++;
            if (obs[d] !== reset_exp()) begin
                bad++;
                $display("FAIL reset_hold dut=%0d got=%h want=%h", d, obs[d], reset_exp());
            end
        end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic rand_instr(output logic [31:0] ins, output logic z);
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [11:0] imm;
        logic        b30;
        rd  = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
        f3  = 3'($urandom); imm = 12'($urandom); b30 = 1'($urandom);
        z   = 1'($urandom);
        case ($urandom_range(0, 5))
            0:       ins = {imm, rs1, 3'b010, rd, 7'b0000011};
            1:       ins = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
            2:       ins = {1'b0, b30, 5'b0, rs2, rs1, f3, rd, 7'b0110011};
            3:       ins = {imm, rs1, f3, rd, 7'b0010011};
            4:       ins = {imm[11:5], rs2, rs1, 2'b00, b30, imm[4:0], 7'b1100011};
            default: ins = {imm, rs1, 3'b000, rd, 7'b1101111};
        endcase
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_add();
        bit tr;
        do_reset();
        run_instr(0, 32'h002081B3, 1'b0, -1, 0, 1000, "add", tr);
        run_instr(0, 32'h402081B3, 1'b0, -1, 0, 1000, "sub", tr);
        run_instr(0, 32'h4020D1B3, 1'b0, -1, 0, 1000, "sra", tr);
    endtask

    task automatic test_load_wait();
        bit tr;
        do_reset();
        run_instr(1, 32'h0080A283, 1'b0, -1, 0, 1000, "lw_w2", tr);
        run_instr(1, 32'h0020A423, 1'b0, -1, 0, 1000, "sw_w2", tr);
    endtask

    task automatic test_branch();
        bit tr;
        do_reset();
        run_instr(0, 32'h00208463, 1'b1, -1, 0, 1000, "beq_taken", tr);
        run_instr(0, 32'h00208463, 1'b0, -1, 0, 1000, "beq_not", tr);
        run_instr(0, 32'h00209463, 1'b0, -1, 0, 1000, "bne_taken", tr);
        run_instr(0, 32'h0020C463, 1'b1, -1, 0, 1000, "blt_trap", tr);
    endtask

    task automatic test_jal();
        bit tr;
        do_reset();
        run_instr(0, 32'h010000EF, 1'b0, -1, 0, 1000, "jal_en", tr);
        run_instr(0, 32'h002081B3, 1'b0, -1, 0, 1000, "after_jal", tr);
        do_reset();
        run_instr(2, 32'h010000EF, 1'b0, -1, 0, 1000, "jal_dis", tr);
        do_reset();
    endtask

    task automatic test_illegal();
        logic [6:0] ops [5];
        bit         tr;
        ops = '{7'h00, 7'h37, 7'h17, 7'h67, 7'h73};
        for (int k = 0; k < 5; k++) begin
            do_reset();
            run_instr(0, {25'($urandom), ops[k]}, 1'b0, -1, 0, 1000, "illegal_op", tr);
        end
    endtask

    task automatic test_ena_store();
        bit tr;
        do_reset();
        run_instr(2, 32'h0020A423, 1'b0, 4, 3, 1000, "sw_ena_first", tr);
        run_instr(2, 32'h0020A423, 1'b0, 5, 3, 1000, "sw_ena_last", tr);
        run_instr(2, 32'h0080A283, 1'b0, 1, 2, 1000, "lw_ena_fetch", tr);
    endtask

    task automatic test_reset_mid();
        bit tr;
        do_reset();
        run_instr(1, 32'h0080A283, 1'b0, -1, 0, 6, "lw_pre_abort", tr);
        rst = 1'b0;
        #1;
        total++;
        if (obs[1] !== reset_exp()) begin
            bad++;
            $display("FAIL reset_mid dut=1 got=%h want=%h", obs[1], reset_exp());
        end
        @(posedge clk); #1;
        rst = 1'b1;
        run_instr(1, 32'h0080A283, 1'b0, -1, 0, 1000, "lw_after_abort", tr);
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins;
        logic        z;
        int          drop, len;
        bit          tr;
        for (int d = 0; d < 2; d++) begin
            do_reset();
            for (int n = 0; n < 30; n++) begin
                rand_instr(ins, z);
                drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1;
                len  = int'($urandom_range(1, 3));
                run_instr(d, ins, z, drop, len, 1000, "rand", tr);
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            ena_v[d]   = 1'b1;
            instr_v[d] = 32'h0;
            zero_v[d]  = 1'b0;
        end
        test_reset();
        test_add();
        test_load_wait();
        test_branch();
        test_jal();
        test_illegal();
        test_ena_store();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
